// File: rtl/regfile_scan_reader.sv
`default_nettype none
// ============================================================================
// Module      : regfile_scan_reader
// Description : Walks register-file indices FIRST_REG..LAST_REG through a
//               combinational read port and emits each (index, value) pair
//               on a valid/ready stream. scan_hold stalls core register
//               writes for the whole scan so the dump is a coherent snapshot.
// Options     : REGFILE_SCAN_CHECKSUM_EN adds a wrapping running sum of all
//               accepted beats on the checksum output.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_scan_reader #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              scan_hold,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done
`ifdef REGFILE_SCAN_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    localparam logic [1:0] c_s_idle    = 2'd0;
    localparam logic [1:0] c_s_read    = 2'd1;
    localparam logic [1:0] c_s_present = 2'd2;
    localparam logic [1:0] c_s_done    = 2'd3;

    localparam logic [ADDR_W-1:0] c_first_idx = ADDR_W'(FIRST_REG);
    localparam logic [ADDR_W-1:0] c_last_idx  = ADDR_W'(LAST_REG);
    localparam logic [ADDR_W-1:0] c_idx_one   = ADDR_W'(1);

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_idx;
    logic              r_out_valid;
    logic [ADDR_W-1:0] r_out_addr;
    logic [DATA_W-1:0] r_out_data;
    logic              r_done;

    logic w_handshake;
    logic w_last;

    // A beat is accepted only while it is being presented.
    assign w_handshake = (r_state == c_s_present) && r_out_valid && out_ready;
    // Compare against LAST_REG instead of detecting wrap, so the top index is legal.
    assign w_last      = (r_idx == c_last_idx);

    // Scan sequencer: READ captures the read port, PRESENT holds the beat until accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_s_idle;
            r_idx       <= c_first_idx;
            r_out_valid <= 1'b0;
            r_out_addr  <= '0;
            r_out_data  <= '0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                c_s_idle: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_idx   <= c_first_idx;
                        r_state <= c_s_read;
                    end
                end
                c_s_read: begin
                    r_out_data  <= rf_rdata;
                    r_out_addr  <= r_idx;
                    r_out_valid <= 1'b1;
                    r_state     <= c_s_present;
                end
                c_s_present: begin
                    if (w_handshake) begin
                        r_out_valid <= 1'b0;
                        if (w_last) begin
                            r_done  <= 1'b1;
                            r_state <= c_s_done;
                        end else begin
                            r_idx   <= r_idx + c_idx_one;
                            r_state <= c_s_read;
                        end
                    end
                end
                c_s_done: begin
                    r_done  <= 1'b0;
                    r_state <= c_s_idle;
                end
                default: begin
                    r_state     <= c_s_idle;
                    r_out_valid <= 1'b0;
                    r_done      <= 1'b0;
                end
            endcase
        end
    end

`ifdef REGFILE_SCAN_CHECKSUM_EN
    logic [DATA_W-1:0] r_checksum;

    // Running sum of accepted beats; restarts on every accepted start, wraps on overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_checksum <= '0;
        end else if ((r_state == c_s_idle) && start) begin
            r_checksum <= '0;
        end else if (w_handshake) begin
            r_checksum <= r_checksum + r_out_data;
        end
    end

    assign checksum = r_checksum;
`endif

    assign rf_raddr  = r_idx;
    assign scan_hold = (r_state != c_s_idle);
    assign busy      = (r_state != c_s_idle);
    assign out_valid = r_out_valid;
    assign out_addr  = r_out_addr;
    assign out_data  = r_out_data;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_regfile_scan_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_scan_reader
// Description : Self-checking bench for regfile_scan_reader. A full-range
//               instance and a single-register (31..31) instance share one
//               register-file model; scans are driven with directed and
//               random backpressure and compared with an expected beat list.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_scan_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        ready;
    logic        sel;
    logic [31:0] rf [32];

    logic [4:0]  raddr1, addr1, raddr2, addr2;
    logic [31:0] rdata1, data1, rdata2, data2;
    logic        hold1, valid1, busy1, done1, hold2, valid2, busy2, done2;
    logic        start1, start2;
`ifdef REGFILE_SCAN_CHECKSUM_EN
    logic [31:0] csum1, csum2;
`endif

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] last_sum;

    always #5 clk = ~clk;

    assign rdata1 = rf[raddr1];
    assign rdata2 = rf[raddr2];
    assign start1 = start & ~sel;
    assign start2 = start & sel;

    regfile_scan_reader u_dut (
        .clk(clk), .rst(rst), .start(start1),
        .rf_raddr(raddr1), .rf_rdata(rdata1), .scan_hold(hold1),
        .out_valid(valid1), .out_ready(ready), .out_addr(addr1),
        .out_data(data1), .busy(busy1), .done(done1)
`ifdef REGFILE_SCAN_CHECKSUM_EN
        , .checksum(csum1)
`endif
    );

    regfile_scan_reader #(.FIRST_REG(31), .LAST_REG(31)) u_dut_one (
        .clk(clk), .rst(rst), .start(start2),
        .rf_raddr(raddr2), .rf_rdata(rdata2), .scan_hold(hold2),
        .out_valid(valid2), .out_ready(ready), .out_addr(addr2),
        .out_data(data2), .busy(busy2), .done(done2)
`ifdef REGFILE_SCAN_CHECKSUM_EN
        , .checksum(csum2)
`endif
    );

    // Selected-instance view used by the scan task
    logic        m_valid, m_busy, m_hold, m_done;
    logic [4:0]  m_addr, m_raddr;
    logic [31:0] m_data;
    assign m_valid = sel ? valid2 : valid1;
    assign m_busy  = sel ? busy2  : busy1;
    assign m_hold  = sel ? hold2  : hold1;
    assign m_done  = sel ? done2  : done1;
    assign m_addr  = sel ? addr2  : addr1;
    assign m_raddr = sel ? raddr2 : raddr1;
    assign m_data  = sel ? data2  : data1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // mode 0: ready always high, 1: random ready, 2: ready withheld 3 cycles on beat 5
    task automatic run_scan(input int mode, input bit repulse);
        int  n_beats, first, c, i, dones, busy_cyc, stall_n, delay;
        bit  pv_stall, fin;
        logic [4:0]  h_addr;
        logic [31:0] h_data, sum;
        n_beats  = sel ? 1 : 32;
        first    = sel ? 31 : 0;
        delay    = (mode == 2) ? 3 : 0;
        i = 0; dones = 0; busy_cyc = 0; stall_n = 0; sum = '0;
        pv_stall = 1'b0; fin = 1'b0; h_addr = '0; h_data = '0;
        ready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        c = 0;
        while (!fin) begin
            if (mode == 1) ready = ($urandom_range(0, 2) != 0);
            else if (mode == 2 && m_valid && m_addr == 5 && stall_n < 3) begin
                ready = 1'b0;
                stall_n++;
            end else ready = 1'b1;
            if (repulse) start = (mode == 1) ? ($urandom_range(0, 4) == 0) : (i == 3 || i == 20);
            @(negedge clk);
            if (m_busy) busy_cyc++;
            if (m_busy) check("hold_eq_busy", m_hold, 1);
            if (pv_stall) begin
                check("stall_valid", m_valid, 1);
                check("stall_addr", m_addr, h_addr);
                check("stall_data", m_data, h_data);
            end
            if (m_valid && ready) begin
                check("beat_addr", m_addr, first + i);
                check("beat_data", m_data, rf[first + i]);
                if (mode != 1) check("beat_time", c, 1 + 2 * i + ((mode == 2 && i >= 5) ? 3 : 0));
                sum = sum + m_data;
                i++;
            end
            pv_stall = m_valid && !ready;
            h_addr   = m_addr;
            h_data   = m_data;
            if (m_done) begin
                dones++;
                check("done_after_beats", i, n_beats);
                if (mode != 1) check("done_time", c, 2 * n_beats + delay);
            end
            if (!m_busy) begin
                start = 1'b0;
                fin   = 1'b1;
            end else if (c >= 400) begin
                check("scan_timeout", m_busy, 0);
                start = 1'b0;
                fin   = 1'b1;
            end else begin
                @(posedge clk); #1;
                c++;
            end
        end
        ready = 1'b1;
        check("scan_done_pulses", dones, 1);
        check("scan_beat_count", i, n_beats);
        if (mode != 1) check("busy_cycles", busy_cyc, 2 * n_beats + 1 + delay);
        last_sum = sum;
`ifdef REGFILE_SCAN_CHECKSUM_EN
        check("checksum_model", sel ? csum2 : csum1, sum);
`endif
    endtask

    initial begin
        int c;
        rst = 1'b1; start = 1'b0; ready = 1'b1; sel = 1'b0;
        for (int k = 0; k < 32; k++) rf[k] = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_valid", valid1, 0);
        check("rst_busy", busy1, 0);
        check("rst_hold", hold1, 0);
        check("rst_done", done1, 0);
        check("rst_addr", addr1, 0);
        check("rst_data", data1, 0);
        check("rst_raddr", raddr1, 0);
        check("rst_raddr_one", raddr2, 31);
        @(posedge clk); #1;

        // Ramp pattern, free-flowing sink, start re-pulsed during beats 3 and 20
        for (int k = 0; k < 32; k++) rf[k] = k * 32'h01010101;
        run_scan(0, 1'b1);
        // Sink withholds ready while beat 5 is presented
        run_scan(2, 1'b0);
        // Random contents, random backpressure, random stray starts
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 32; k++) rf[k] = $urandom;
            run_scan(1, 1'b1);
        end

        // Asynchronous reset while beat 10 is presented
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        c = 0;
        while (!(valid1 && addr1 == 10) && c < 100) begin
            @(posedge clk); #1;
            c++;
        end
        check("reach_beat10", addr1, 10);
        #2 rst = 1'b1;
        #1;
        check("abort_valid", valid1, 0);
        check("abort_hold", hold1, 0);
        check("abort_done", done1, 0);
        check("abort_raddr", raddr1, 0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("post_abort_done", done1, 0);
            check("post_abort_busy", busy1, 0);
        end
        @(posedge clk); #1;
        run_scan(0, 1'b0);

        // Single-register instance
        sel = 1'b1;
        rf[31] = 32'hDEADBEEF;
        run_scan(0, 1'b0);
        check("one_beat_data", last_sum, 32'hDEADBEEF);
        sel = 1'b0;

`ifdef REGFILE_SCAN_CHECKSUM_EN
        for (int k = 0; k < 32; k++) rf[k] = k;
        run_scan(0, 1'b0);
        check("checksum_ramp", csum1, 32'h000001F0);
        for (int k = 0; k < 32; k++) rf[k] = 32'hFFFFFFFF;
        run_scan(1, 1'b0);
        check("checksum_wrap", csum1, 32'hFFFFFFE0);
        repeat (3) @(posedge clk);
        #1 check("checksum_hold", csum1, 32'hFFFFFFE0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
